// File: rtl/pkg_dtypes.sv
// Shared datatypes for the interconnect back end: instruction, receiver list
// and execution-unit address types, plus a coverage helper.
package pkg_dtypes;

  localparam int ICON_NUM_RECEIVERS = 8;
  localparam int EXEC_UNIT_ADDR_W   = 8;

  typedef logic [ICON_NUM_RECEIVERS-1:0] type_icon_receivers_list;
  typedef logic [EXEC_UNIT_ADDR_W-1:0]   type_exec_unit_addr;

  typedef struct packed {
    type_exec_unit_addr      src_addr;
    type_icon_receivers_list receiver_list;
  } type_icon_instr;

  // True when every receiver in need is also present in have.
  function automatic logic list_covered(input type_icon_receivers_list need,
                                        input type_icon_receivers_list have);
    return ((need & ~have) == {ICON_NUM_RECEIVERS{1'b0}});
  endfunction

endpackage

// File: rtl/back_icon_rr_controller_if.sv
// Dispatch / grant / success bundle between the instruction source, the
// receivers and the round-robin controller.
interface back_icon_rr_controller_if
  import pkg_dtypes::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int LOG2_QUEUE_LENGTH = 2
);

  type_icon_instr          [NUM_ICON_CHANNELS-1:0]                      icon_instr_dispatch_i;
  logic                    [NUM_ICON_CHANNELS-1:0]                      icon_instr_dispatch_valid_i;
  logic                    [NUM_ICON_CHANNELS-1:0]                      icon_instr_dispatch_ready_o;
  type_exec_unit_addr      [NUM_ICON_CHANNELS-1:0]                      src_addrs_o;
  type_icon_receivers_list [NUM_ICON_CHANNELS-1:0]                      receiver_lists_o;
  type_icon_receivers_list [NUM_ICON_CHANNELS-1:0]                      success_lists_i;
  logic                    [NUM_ICON_CHANNELS-1:0]                      retire_o;
  logic                    [NUM_ICON_CHANNELS-1:0][LOG2_QUEUE_LENGTH:0] occupancy_o;

  modport master (
    output icon_instr_dispatch_i, icon_instr_dispatch_valid_i, success_lists_i,
    input  icon_instr_dispatch_ready_o, src_addrs_o, receiver_lists_o, retire_o, occupancy_o
  );

  modport slave (
    input  icon_instr_dispatch_i, icon_instr_dispatch_valid_i, success_lists_i,
    output icon_instr_dispatch_ready_o, src_addrs_o, receiver_lists_o, retire_o, occupancy_o
  );

endinterface

// File: rtl/back_icon_iqueue_p.sv
// Per-channel instruction FIFO; push is refused when full, even alongside a pop.
module back_icon_iqueue_p
  import pkg_dtypes::*;
#(
  parameter int LOG2_QUEUE_LENGTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  type_icon_instr               push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [LOG2_QUEUE_LENGTH:0]   count,
  output type_icon_instr               head
);

  localparam int DEPTH = 2 ** LOG2_QUEUE_LENGTH;
  localparam int PTR_W = LOG2_QUEUE_LENGTH;
  localparam int CNT_W = LOG2_QUEUE_LENGTH + 1;

  type_icon_instr     mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/back_icon_rr_controller.sv
// Multi-channel instruction controller: queues instructions per channel and
// arbitrates receivers across channel heads with a rotating priority pointer.
module back_icon_rr_controller
  import pkg_dtypes::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int LOG2_QUEUE_LENGTH = 2,
  parameter int RR_ENABLE         = 1
) (
  input logic                        clk,
  input logic                        reset_n,
  back_icon_rr_controller_if.slave   icon
);

  localparam int CH    = NUM_ICON_CHANNELS;
  localparam int PTR_W = $clog2(CH);
  localparam int CNT_W = LOG2_QUEUE_LENGTH + 1;

  type_icon_instr          head_s     [CH];
  logic [CNT_W-1:0]        count_s    [CH];
  logic [CH-1:0]           full_s;
  logic [CH-1:0]           empty_s;
  logic [CH-1:0]           retire_s;
  type_icon_receivers_list latch_r    [CH];
  type_icon_receivers_list pending_s  [CH];
  type_icon_receivers_list grant_s    [CH];
  type_icon_receivers_list captured_s [CH];
  type_icon_receivers_list taken_s;
  logic [PTR_W-1:0]        ptr_r;
  logic                    any_grant_s;
  int                      idx_s;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    back_icon_iqueue_p #(
      .LOG2_QUEUE_LENGTH (LOG2_QUEUE_LENGTH)
    ) u_iqueue (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (icon.icon_instr_dispatch_valid_i[c]),
      .push_data (icon.icon_instr_dispatch_i[c]),
      .pop       (retire_s[c]),
      .full      (full_s[c]),
      .empty     (empty_s[c]),
      .count     (count_s[c]),
      .head      (head_s[c])
    );

    assign icon.icon_instr_dispatch_ready_o[c] = ~full_s[c];
    assign icon.src_addrs_o[c]      = empty_s[c] ? type_exec_unit_addr'(0) : head_s[c].src_addr;
    assign icon.receiver_lists_o[c] = grant_s[c];
    assign icon.retire_o[c]         = retire_s[c];
    assign icon.occupancy_o[c]      = count_s[c];
  end

  // Grant chain starts at the priority pointer; earlier channels mask later ones.
  always_comb begin
    taken_s = type_icon_receivers_list'(0);
    idx_s   = 0;
    for (int c = 0; c < CH; c++) begin
      grant_s[c] = type_icon_receivers_list'(0);
      if (reset_n && !empty_s[c]) begin
        pending_s[c] = head_s[c].receiver_list & ~latch_r[c];
      end else begin
        pending_s[c] = type_icon_receivers_list'(0);
      end
    end
    for (int k = 0; k < CH; k++) begin
      idx_s          = (int'(ptr_r) + k) % CH;
      grant_s[idx_s] = pending_s[idx_s] & ~taken_s;
      taken_s        = taken_s | grant_s[idx_s];
    end
    any_grant_s = (taken_s != type_icon_receivers_list'(0));
  end

  // Success only counts for receivers granted this cycle.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      captured_s[c] = latch_r[c] | (icon.success_lists_i[c] & grant_s[c]);
      retire_s[c]   = reset_n & ~empty_s[c] &
                      list_covered(head_s[c].receiver_list, captured_s[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!reset_n || retire_s[c]) begin
        latch_r[c] <= type_icon_receivers_list'(0);
      end else begin
        latch_r[c] <= captured_s[c];
      end
    end
  end

  // Fixed-priority builds never move the pointer off channel 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r <= PTR_W'(0);
    end else if ((RR_ENABLE != 0) && any_grant_s) begin
      ptr_r <= (ptr_r == PTR_W'(CH - 1)) ? PTR_W'(0) : ptr_r + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: tb/tb_back_icon_rr_controller.sv
// Directed bench: a rotating-priority and a fixed-priority instance share the
// same stimulus; expected values are hand-computed constants.
module tb_back_icon_rr_controller;
  import pkg_dtypes::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  back_icon_rr_controller_if #(.NUM_ICON_CHANNELS(4), .LOG2_QUEUE_LENGTH(2)) ifc ();
  back_icon_rr_controller_if #(.NUM_ICON_CHANNELS(4), .LOG2_QUEUE_LENGTH(2)) ifc_fp ();

  assign ifc_fp.icon_instr_dispatch_i       = ifc.icon_instr_dispatch_i;
  assign ifc_fp.icon_instr_dispatch_valid_i = ifc.icon_instr_dispatch_valid_i;
  assign ifc_fp.success_lists_i             = ifc.success_lists_i;

  back_icon_rr_controller #(.NUM_ICON_CHANNELS(4), .LOG2_QUEUE_LENGTH(2), .RR_ENABLE(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .icon    (ifc)
  );

  back_icon_rr_controller #(.NUM_ICON_CHANNELS(4), .LOG2_QUEUE_LENGTH(2), .RR_ENABLE(0)) dut_fp (
    .clk     (clk),
    .reset_n (reset_n),
    .icon    (ifc_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 4; c++) begin
      ifc.icon_instr_dispatch_i[c] = type_icon_instr'(16'h0000);
      ifc.success_lists_i[c]       = 8'h00;
    end
    ifc.icon_instr_dispatch_valid_i = 4'b0000;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic dispatch(input int ch, input logic [7:0] src, input logic [7:0] list);
    ifc.icon_instr_dispatch_i[ch]       = type_icon_instr'({src, list});
    ifc.icon_instr_dispatch_valid_i[ch] = 1'b1;
  endtask

  initial begin
    logic [7:0] src_v;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();

    // Reset state
    do_reset();
    check_val("rst_grants", ifc.receiver_lists_o, 32'h0);
    check_val("rst_src", ifc.src_addrs_o, 32'h0);
    check_val("rst_retire", 32'(ifc.retire_o), 32'h0);
    check_val("rst_occ", 32'(ifc.occupancy_o), 32'h0);
    check_val("rst_ready", 32'(ifc.icon_instr_dispatch_ready_o), 32'hF);

    // Partial success on channel 0
    dispatch(0, 8'h12, 8'h0F);
    #1 check_val("p_ready0", 32'(ifc.icon_instr_dispatch_ready_o[0]), 32'h1);
    check_val("p_not_visible", 32'(ifc.src_addrs_o[0]), 32'h0);
    tick();
    clear_inputs();
    #1 check_val("p_src0", 32'(ifc.src_addrs_o[0]), 32'h12);
    check_val("p_grant0_a", 32'(ifc.receiver_lists_o[0]), 32'h0F);
    ifc.success_lists_i[0] = 8'h03;
    #1 check_val("p_retire_a", 32'(ifc.retire_o), 32'h0);
    tick();
    ifc.success_lists_i[0] = 8'h00;
    #1 check_val("p_grant0_b", 32'(ifc.receiver_lists_o[0]), 32'h0C);
    ifc.success_lists_i[0] = 8'h0C;
    #1 check_val("p_retire_b", 32'(ifc.retire_o), 32'h1);
    tick();
    ifc.success_lists_i[0] = 8'h00;
    #1 check_val("p_grant_after", ifc.receiver_lists_o, 32'h0);
    check_val("p_src_after", 32'(ifc.src_addrs_o[0]), 32'h0);
    check_val("p_retire_after", 32'(ifc.retire_o), 32'h0);
    check_val("p_occ_after", 32'(ifc.occupancy_o[0]), 32'h0);

    // Conflict on receiver 0 between channels 0 and 1
    do_reset();
    dispatch(0, 8'hA0, 8'h01);
    dispatch(1, 8'hB1, 8'h01);
    tick();
    clear_inputs();
    #1 check_val("c_rr_ch0_t0", 32'(ifc.receiver_lists_o[0]), 32'h01);
    check_val("c_rr_ch1_t0", 32'(ifc.receiver_lists_o[1]), 32'h00);
    check_val("c_fp_ch0_t0", 32'(ifc_fp.receiver_lists_o[0]), 32'h01);
    tick();
    check_val("c_rr_ch1_t1", 32'(ifc.receiver_lists_o[1]), 32'h01);
    check_val("c_rr_ch0_t1", 32'(ifc.receiver_lists_o[0]), 32'h00);
    check_val("c_fp_ch0_t1", 32'(ifc_fp.receiver_lists_o[0]), 32'h01);
    check_val("c_fp_ch1_t1", 32'(ifc_fp.receiver_lists_o[1]), 32'h00);
    tick();
    check_val("c_rr_ch0_t2", 32'(ifc.receiver_lists_o[0]), 32'h01);
    check_val("c_rr_ch1_t2", 32'(ifc.receiver_lists_o[1]), 32'h00);

    // Fill channel 2, refuse extra pushes, then pop one
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_v = 8'h20 + 8'(i);
      dispatch(2, src_v, 8'h10);
      tick();
    end
    dispatch(2, 8'h24, 8'h10);
    #1 check_val("f_ready2", 32'(ifc.icon_instr_dispatch_ready_o[2]), 32'h0);
    check_val("f_occ2", 32'(ifc.occupancy_o[2]), 32'h4);
    check_val("f_src2_head", 32'(ifc.src_addrs_o[2]), 32'h20);
    tick();
    check_val("f_occ2_refused", 32'(ifc.occupancy_o[2]), 32'h4);
    ifc.success_lists_i[2] = 8'h10;
    #1 check_val("f_retire2", 32'(ifc.retire_o), 32'h4);
    tick();
    clear_inputs();
    #1 check_val("f_occ2_after", 32'(ifc.occupancy_o[2]), 32'h3);
    check_val("f_ready2_after", 32'(ifc.icon_instr_dispatch_ready_o[2]), 32'h1);
    check_val("f_src2_next", 32'(ifc.src_addrs_o[2]), 32'h21);

    // Empty receiver list retires immediately
    do_reset();
    dispatch(3, 8'h33, 8'h00);
    tick();
    clear_inputs();
    #1 check_val("e_retire", 32'(ifc.retire_o), 32'h8);
    check_val("e_grants", ifc.receiver_lists_o, 32'h0);
    check_val("e_src3", 32'(ifc.src_addrs_o[3]), 32'h33);
    tick();
    check_val("e_retire_after", 32'(ifc.retire_o), 32'h0);
    check_val("e_occ3_after", 32'(ifc.occupancy_o[3]), 32'h0);

    // Reset with a partially delivered instruction
    do_reset();
    dispatch(1, 8'h44, 8'h0F);
    tick();
    clear_inputs();
    ifc.success_lists_i[1] = 8'h03;
    tick();
    ifc.success_lists_i[1] = 8'h00;
    #1 check_val("m_grant1_latched", 32'(ifc.receiver_lists_o[1]), 32'h0C);
    reset_n = 1'b0;
    #1 check_val("m_retire_in_rst", 32'(ifc.retire_o), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    #1 check_val("m_occ", 32'(ifc.occupancy_o), 32'h0);
    check_val("m_retire", 32'(ifc.retire_o), 32'h0);
    check_val("m_grants", ifc.receiver_lists_o, 32'h0);
    tick();
    check_val("m_retire_later", 32'(ifc.retire_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/back_icon_rr_controller.md
BACK_ICON_RR_CONTROLLER -- requirements
Module: back_icon_rr_controller

Interface
REQ-001 SHALL have parameter NUM_ICON_CHANNELS, default 4: number of interconnect channels, range 2..8.
REQ-002 SHALL have parameter LOG2_QUEUE_LENGTH, default 2: per-channel queue depth is 2**LOG2_QUEUE_LENGTH.
REQ-003 SHALL have parameter RR_ENABLE, default 1: 1 selects rotating priority, 0 selects fixed priority with channel 0 highest.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port icon_instr_dispatch_i, input, type_icon_instr [CH]: per-channel instruction (src_addr, receiver_list).
REQ-007 SHALL have port icon_instr_dispatch_valid_i, input, 1 bit [CH]: dispatch valid.
REQ-008 SHALL have port icon_instr_dispatch_ready_o, output, 1 bit [CH]: queue not full.
REQ-009 SHALL have port src_addrs_o, output, type_exec_unit_addr [CH]: head source address; 0 when head invalid.
REQ-010 SHALL have port receiver_lists_o, output, type_icon_receivers_list [CH]: receivers granted this cycle.
REQ-011 SHALL have port success_lists_i, input, type_icon_receivers_list [CH]: receivers that captured data this cycle.
REQ-012 SHALL have port retire_o, output, 1 bit [CH]: one-cycle pulse when the head instruction completes.
REQ-013 SHALL have port occupancy_o, output, LOG2_QUEUE_LENGTH+1 bits [CH]: queue entry count.

Function
REQ-014 Dispatch SHALL be accepted when valid and ready are both 1; the entry is visible at the head no earlier than the next cycle.
REQ-015 Ready SHALL be low when the queue is full, with no bypass; a push in the same cycle as a pop on a full queue is refused.
REQ-016 Each channel SHALL keep a latched success list; latch <= latch | (success_lists_i & receiver_lists_o).
REQ-017 Success bits for receivers not granted in that cycle SHALL be ignored.
REQ-018 The pending list SHALL be head.receiver_list & ~latch when the head is valid, and 0 otherwise.
REQ-019 Arbitration SHALL scan channels from the priority pointer upward, modulo CH.
REQ-020 Each channel SHALL be granted its pending receivers not already granted to an earlier-scanned channel.
REQ-021 No receiver bit SHALL appear in more than one receiver_lists_o entry in the same cycle.
REQ-022 The priority pointer SHALL advance by 1 (wrapping CH-1 to 0) in any cycle with at least one nonzero grant when RR_ENABLE=1.
REQ-023 The priority pointer SHALL be held at 0 when RR_ENABLE=0.
REQ-024 The head SHALL retire in the cycle where (latch | (success_lists_i & receiver_lists_o)) covers head.receiver_list.
REQ-025 On retire, retire_o SHALL pulse, the queue SHALL pop, and the latch SHALL clear to 0 next cycle.
REQ-026 A valid head with an empty receiver_list SHALL retire in its first head cycle with a zero grant.
REQ-027 Back-to-back retirement SHALL be supported: a new head is arbitrated in the cycle after a pop.
REQ-028 Queue pointers SHALL wrap modulo depth.
REQ-029 occupancy_o SHALL update on every push, pop, and simultaneous push/pop (net unchanged).

Reset
REQ-030 While reset_n=0 at a clock edge, queues, latches, and the pointer SHALL clear.
REQ-031 After reset, receiver_lists_o, src_addrs_o, retire_o, and occupancy_o SHALL be 0 and ready SHALL be 1.
REQ-032 Reset mid-transfer SHALL discard all queued and partially delivered instructions, with no retire pulse.

Structure
REQ-033 type_icon_instr, type_icon_receivers_list, type_exec_unit_addr, ICON_NUM_RECEIVERS, and EXEC_UNIT_ADDR_W SHALL reside in pkg_dtypes.
REQ-034 The per-channel FIFO SHALL be sub-module back_icon_iqueue_p, parametrised by LOG2_QUEUE_LENGTH, exposing full, empty, count, head, and pop.
REQ-035 Arbitration SHALL be combinational, with the grant chain rotated by the pointer; success latches and the pointer SHALL live in the top module.

Verification (CH=4, 8 receivers, LOG2_QUEUE_LENGTH=2)
REQ-036 Reset check: hold reset_n=0 then release -> all outputs 0, all ready 1.
REQ-037 Partial success: ch0 dispatch src=0x12, list=0x0F; success 0x03, then 0x0C -> grants 0x0F then 0x0C; retire_o[0] pulses with the second success; next cycle grants and src are 0.
REQ-038 Conflict with rotation: ch0 and ch1 both list 0x01, pointer=0, no success -> ch0 granted 0x01, ch1 granted 0x00; next cycle ch1 granted 0x01, ch0 0x00; with RR_ENABLE=0, ch0 keeps 0x01.
REQ-039 Full queue: 4 dispatches to ch2 with no success -> ready[2]=0 and occupancy=4; a 5th valid is not accepted; after one retire, ready[2]=1 and occupancy=3.
REQ-040 Empty list: dispatch list=0x00 -> retire_o pulses on its first head cycle with receiver_lists_o=0.
REQ-041 Mid-operation reset: reset asserted with latch=0x03 pending -> after reset, occupancy=0 and no retire pulse.
